clint_timer: RTL

Core-local interrupt timer for the SoC. It sits upstream of the CPU's interrupt inputs and drives `timer_interrupt` and `software_interrupt` into the top level. It is memory-mapped on the CPU data port, in parallel with data memory, and shares the CPU's read/write address, write-data and enable signals. It holds a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and a one-bit `msip`, with register offsets laid out in the standard RISC-V CLINT arrangement.

---
 rtl/clint_timer.sv | 106 ++++++++++
 1 files changed

// File: rtl/clint_timer.sv
// Core-local interrupt timer: free-running 64-bit mtime with prescaler, mtimecmp
// comparator and msip bit, in the standard CLINT register layout.
module clint_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] write_addr,
    input  logic [31:0] read_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic        timer_interrupt,
    output logic        software_interrupt
);

    // Word offsets within the window (byte offset >> 2)
    localparam logic [13:0] OFF_MSIP     = 14'h0000;
    localparam logic [13:0] OFF_CMP_LO   = 14'h1000;
    localparam logic [13:0] OFF_CMP_HI   = 14'h1001;
    localparam logic [13:0] OFF_MTIME_LO = 14'h2FFE;
    localparam logic [13:0] OFF_MTIME_HI = 14'h2FFF;
    localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        timer_irq_q, timer_irq_d;

    logic        tick;
    logic        wr_hit;
    logic [13:0] wr_off;
    logic [13:0] rd_off;
    logic        unused_addr_bits;

    assign wr_hit = wr_en && (write_addr[31:16] == BASE_ADDR[31:16]);
    assign wr_off = write_addr[15:2];
    assign rd_off = read_addr[15:2];
    assign unused_addr_bits = ^{read_addr[1:0], write_addr[1:0]};

    always_comb begin
        presc_d     = presc_q;
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        timer_irq_d = (mtime_q >= mtimecmp_q);

        tick    = (presc_q == PRESCALE_MAX);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;

        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        // A store to either mtime half overrides that cycle's increment
        if (wr_hit) begin
            case (wr_off)
                OFF_MSIP:     msip_d     = wr_data[0];
                OFF_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], wr_data};
                OFF_CMP_HI:   mtimecmp_d = {wr_data, mtimecmp_q[31:0]};
                OFF_MTIME_LO: mtime_d    = {mtime_q[63:32], wr_data};
                OFF_MTIME_HI: mtime_d    = {wr_data, mtime_q[31:0]};
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= 16'd0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q      <= 1'b0;
            timer_irq_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    always_comb begin
        rd_hit  = rd_en && (read_addr[31:16] == BASE_ADDR[31:16]);
        rd_data = 32'd0;
        if (rd_hit) begin
            case (rd_off)
                OFF_MSIP:     rd_data = {31'd0, msip_q};
                OFF_CMP_LO:   rd_data = mtimecmp_q[31:0];
                OFF_CMP_HI:   rd_data = mtimecmp_q[63:32];
                OFF_MTIME_LO: rd_data = mtime_q[31:0];
                OFF_MTIME_HI: rd_data = mtime_q[63:32];
                default:      rd_data = 32'd0;
            endcase
        end
    end

    assign timer_interrupt    = timer_irq_q;
    assign software_interrupt = msip_q;

endmodule
